lookup_engine_pipe: RTL and testbench

// - Parametrised, fully pipelined successor of the stage lookup engine: ternary match of extract_key against DEPTH entries, then action RAM read.
// - Sits between key extractor and action engine in every stage; carries PHV alongside; accepts one key per cycle (no idle states between keys).
// - Entries and actions written at runtime via control channel; table is empty after reset.

---
 rtl/lookup_engine_pipe.sv | 146 ++++++++++++++
 tb/tb_lookup_engine_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lookup_engine_pipe.sv
// Pipelined ternary lookup: P1 match, P2 priority encode + action RAM read, P3 output register.
// Optional per-entry hit counters when LKUP_HIT_CNT_EN is defined.
module lookup_engine_pipe #(
   parameter int                 STAGE   = 0,
   parameter int                 PHV_LEN = 48*8+32*8+16*8+5*20+256,
   parameter int                 KEY_LEN = 197,
   parameter int                 ACT_LEN = 625,
   parameter int                 DEPTH   = 16,
   parameter logic [ACT_LEN-1:0] DEF_ACT = 625'h3f,
   localparam int                AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [KEY_LEN-1:0] extract_key,
   input  logic               key_valid,
   input  logic [PHV_LEN-1:0] phv_in,
   output logic [ACT_LEN-1:0] action,
   output logic               action_valid,
   output logic [PHV_LEN-1:0] phv_out,
   output logic               action_hit,
   input  logic [KEY_LEN-1:0] lookup_din,
   input  logic [KEY_LEN-1:0] lookup_din_mask,
   input  logic               lookup_din_vld,
   input  logic [AW-1:0]      lookup_din_addr,
   input  logic               lookup_din_en,
   input  logic [ACT_LEN-1:0] action_data_in,
   input  logic [AW-1:0]      action_addr,
   input  logic               action_en
`ifdef LKUP_HIT_CNT_EN
   ,
   input  logic [AW-1:0]      cnt_rd_addr,
   input  logic               cnt_clr,
   output logic [31:0]        cnt_rd_data
`endif
);

   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || STAGE < 0) begin : g_bad_cfg
      $error("lookup_engine_pipe: DEPTH must be a power of 2 in 2..64");
   end

   logic [KEY_LEN-1:0] ent_key  [DEPTH];
   logic [KEY_LEN-1:0] ent_mask [DEPTH];
   logic [DEPTH-1:0]   ent_vld;
   logic [ACT_LEN-1:0] act_ram  [DEPTH];

   logic [DEPTH-1:0]   hit_comb;
   logic [DEPTH-1:0]   hit_q;
   logic [PHV_LEN-1:0] phv1, phv2;
   logic               vld1, vld2, any2;
   logic [ACT_LEN-1:0] ram_q;
   logic [AW-1:0]      win_idx;
   logic               win_any;

   always_comb begin
      hit_comb = '0;
      for (int unsigned i = 0; i < DEPTH; i++)
         hit_comb[i] = ent_vld[i] & ~|((extract_key ^ ent_key[i]) & ~ent_mask[i]);
   end

   // Lowest index wins.
   always_comb begin
      win_idx = '0;
      win_any = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (hit_q[i] && !win_any) begin
            win_idx = AW'(i);
            win_any = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (lookup_din_en) begin
         ent_key[lookup_din_addr]  <= lookup_din;
         ent_mask[lookup_din_addr] <= lookup_din_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ent_vld <= '0;
      else if (lookup_din_en)
         ent_vld[lookup_din_addr] <= lookup_din_vld;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            act_ram[i] <= '0;
      end else if (action_en) begin
         act_ram[action_addr] <= action_data_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld1         <= 1'b0;
         hit_q        <= '0;
         phv1         <= '0;
         vld2         <= 1'b0;
         any2         <= 1'b0;
         phv2         <= '0;
         ram_q        <= '0;
         action_valid <= 1'b0;
         action       <= '0;
         action_hit   <= 1'b0;
         phv_out      <= '0;
      end else begin
         vld1         <= key_valid;
         hit_q        <= hit_comb;
         phv1         <= phv_in;
         vld2         <= vld1;
         any2         <= win_any;
         phv2         <= phv1;
         ram_q        <= act_ram[win_idx];
         action_valid <= vld2;
         if (vld2) begin
            action     <= any2 ? ram_q : DEF_ACT;
            action_hit <= any2;
            phv_out    <= phv2;
         end
      end
   end

`ifdef LKUP_HIT_CNT_EN
   logic [31:0] hit_cnt [DEPTH];

   // Clear (global or on entry rewrite) takes priority over a same-cycle increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++)
            hit_cnt[i] <= '0;
         cnt_rd_data <= '0;
      end else begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (cnt_clr || (lookup_din_en && lookup_din_addr == AW'(i)))
               hit_cnt[i] <= '0;
            else if (vld1 && win_any && win_idx == AW'(i) && hit_cnt[i] != '1)
               hit_cnt[i] <= hit_cnt[i] + 32'd1;
         end
         cnt_rd_data <= hit_cnt[cnt_rd_addr];
      end
   end
`endif

endmodule

// File: tb/tb_lookup_engine_pipe.sv
// Directed bench for lookup_engine_pipe: vector table for back-to-back lookups plus hand sequences.
// Counter checks are compiled in when LKUP_HIT_CNT_EN is defined.
module tb_lookup_engine_pipe;
   localparam int PHV_LEN = 1124;
   localparam int KEY_LEN = 197;
   localparam int ACT_LEN = 625;
   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam logic [ACT_LEN-1:0] DEF = 625'h3f;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [KEY_LEN-1:0] extract_key = '0;
   logic               key_valid = 1'b0;
   logic [PHV_LEN-1:0] phv_in = '0;
   logic [ACT_LEN-1:0] action;
   logic               action_valid;
   logic [PHV_LEN-1:0] phv_out;
   logic               action_hit;
   logic [KEY_LEN-1:0] lookup_din = '0;
   logic [KEY_LEN-1:0] lookup_din_mask = '0;
   logic               lookup_din_vld = 1'b0;
   logic [AW-1:0]      lookup_din_addr = '0;
   logic               lookup_din_en = 1'b0;
   logic [ACT_LEN-1:0] action_data_in = '0;
   logic [AW-1:0]      action_addr = '0;
   logic               action_en = 1'b0;
`ifdef LKUP_HIT_CNT_EN
   logic [AW-1:0]      cnt_rd_addr = '0;
   logic               cnt_clr = 1'b0;
   logic [31:0]        cnt_rd_data;
`endif

   lookup_engine_pipe #(
      .STAGE(0), .PHV_LEN(PHV_LEN), .KEY_LEN(KEY_LEN), .ACT_LEN(ACT_LEN),
      .DEPTH(DEPTH), .DEF_ACT(DEF)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .extract_key(extract_key), .key_valid(key_valid), .phv_in(phv_in),
      .action(action), .action_valid(action_valid), .phv_out(phv_out), .action_hit(action_hit),
      .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask), .lookup_din_vld(lookup_din_vld),
      .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
      .action_data_in(action_data_in), .action_addr(action_addr), .action_en(action_en)
`ifdef LKUP_HIT_CNT_EN
      , .cnt_rd_addr(cnt_rd_addr), .cnt_clr(cnt_clr), .cnt_rd_data(cnt_rd_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [KEY_LEN-1:0] key;
      logic [PHV_LEN-1:0] phv;
      logic [ACT_LEN-1:0] act;
      logic               hit;
   } vec_t;

   vec_t tbl [16];
   int   n_chk  = 0;
   int   n_fail = 0;

   localparam logic [KEY_LEN-1:0] K  = 197'h1f_0123_4567_89ab_cdef_fedc_ba98_7654_3210_dead_beef;
   localparam logic [KEY_LEN-1:0] K2 = K ^ (197'h1 << 100);
   localparam logic [KEY_LEN-1:0] K3 = K ^ (197'h1 << 196);
   localparam logic [ACT_LEN-1:0] A = 625'ha11a, B = 625'hb22b, C = 625'hc33c;
   localparam logic [ACT_LEN-1:0] D = 625'hd44d, E = 625'he55e, F = 625'hf66f;

   task automatic chk(input string nm, input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, got[255:0], exp[255:0]);
      end
   endtask

   task automatic write_entry(input logic [AW-1:0] a, input logic [KEY_LEN-1:0] k,
                              input logic [KEY_LEN-1:0] m, input logic v);
      lookup_din_addr = a; lookup_din = k; lookup_din_mask = m; lookup_din_vld = v; lookup_din_en = 1'b1;
      @(negedge clk);
      lookup_din_en = 1'b0;
   endtask

   task automatic write_action(input logic [AW-1:0] a, input logic [ACT_LEN-1:0] d);
      action_addr = a; action_data_in = d; action_en = 1'b1;
      @(negedge clk);
      action_en = 1'b0;
   endtask

   task automatic expect_out(input string nm, input logic [ACT_LEN-1:0] ea, input logic eh,
                             input logic [PHV_LEN-1:0] ep);
      chk({nm, ".valid"}, PHV_LEN'(action_valid), PHV_LEN'(1'b1));
      chk({nm, ".action"}, PHV_LEN'(action), PHV_LEN'(ea));
      chk({nm, ".hit"}, PHV_LEN'(action_hit), PHV_LEN'(eh));
      chk({nm, ".phv"}, phv_out, ep);
   endtask

   // Single isolated key; strobe must appear on exactly the third negedge.
   task automatic lookup(input string nm, input logic [KEY_LEN-1:0] k, input logic [PHV_LEN-1:0] p,
                         input logic [ACT_LEN-1:0] ea, input logic eh);
      int got_c;
      logic [ACT_LEN-1:0] ga;
      logic gh;
      logic [PHV_LEN-1:0] gp;
      got_c = 0; ga = '0; gh = 1'b0; gp = '0;
      extract_key = k; phv_in = p; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         if (action_valid && got_c == 0) begin
            got_c = c; ga = action; gh = action_hit; gp = phv_out;
         end
         if (c < 6) @(negedge clk);
      end
      chk({nm, ".latency"}, PHV_LEN'(got_c), PHV_LEN'(3));
      if (got_c != 0) begin
         chk({nm, ".action"}, PHV_LEN'(ga), PHV_LEN'(ea));
         chk({nm, ".hit"}, PHV_LEN'(gh), PHV_LEN'(eh));
         chk({nm, ".phv"}, gp, p);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 16; i++) begin
         tbl[i].phv = PHV_LEN'(32'hABC0_0000 + i) | (PHV_LEN'(i + 1) << 1100);
         if (i % 2 == 0) begin
            tbl[i].key = K;  tbl[i].act = A;   tbl[i].hit = 1'b1;
         end else begin
            tbl[i].key = K ^ KEY_LEN'(i); tbl[i].act = DEF; tbl[i].hit = 1'b0;
         end
      end

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      chk("reset.valid", PHV_LEN'(action_valid), '0);
      chk("reset.action", PHV_LEN'(action), '0);
      chk("reset.hit", PHV_LEN'(action_hit), '0);
      chk("reset.phv", phv_out, '0);
      @(negedge clk);

      lookup("empty", '0, PHV_LEN'(1), DEF, 1'b0);

      write_entry(4'd5, K, '0, 1'b1);
      write_action(4'd5, A);

      for (int c = 0; c < 19; c++) begin
         if (c >= 3)
            expect_out($sformatf("vec%0d", c - 3), tbl[c-3].act, tbl[c-3].hit, tbl[c-3].phv);
         else
            chk($sformatf("vec_pre%0d.valid", c), PHV_LEN'(action_valid), '0);
         if (c < 16) begin
            extract_key = tbl[c].key; phv_in = tbl[c].phv; key_valid = 1'b1;
         end else begin
            key_valid = 1'b0;
         end
         @(negedge clk);
      end

      // Action write to the address being read returns old data for that read only.
      extract_key = K; phv_in = PHV_LEN'(16'h00a0); key_valid = 1'b1;
      @(negedge clk);
      phv_in = PHV_LEN'(16'h00b0);
      action_addr = 4'd5; action_data_in = B; action_en = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; action_en = 1'b0;
      @(negedge clk);
      expect_out("ram_old", A, 1'b1, PHV_LEN'(16'h00a0));
      @(negedge clk);
      expect_out("ram_new", B, 1'b1, PHV_LEN'(16'h00b0));
      @(negedge clk);
      chk("bubble.valid", PHV_LEN'(action_valid), '0);
      chk("bubble.action_hold", PHV_LEN'(action), PHV_LEN'(B));
      chk("bubble.phv_hold", phv_out, PHV_LEN'(16'h00b0));

      write_entry(4'd2, '0, '1, 1'b1);
      write_action(4'd2, C);
      write_entry(4'd7, K, '0, 1'b1);
      write_action(4'd7, D);
      lookup("wild_prio", K, PHV_LEN'(2), C, 1'b1);
      lookup("wild_any", KEY_LEN'(5), PHV_LEN'(3), C, 1'b1);
      write_entry(4'd2, '0, '0, 1'b0);
      lookup("del2", K, PHV_LEN'(4), B, 1'b1);
      write_entry(4'd5, '0, '0, 1'b0);
      lookup("del5", K, PHV_LEN'(5), D, 1'b1);

      // Entry write concurrent with a matching key: that key misses, the next one hits.
      write_action(4'd3, E);
      lookup_din_addr = 4'd3; lookup_din = K2; lookup_din_mask = '0; lookup_din_vld = 1'b1;
      lookup_din_en = 1'b1;
      extract_key = K2; phv_in = PHV_LEN'(16'h00c0); key_valid = 1'b1;
      @(negedge clk);
      lookup_din_en = 1'b0; phv_in = PHV_LEN'(16'h00d0);
      @(negedge clk);
      key_valid = 1'b0;
      @(negedge clk);
      expect_out("wr_same", DEF, 1'b0, PHV_LEN'(16'h00c0));
      @(negedge clk);
      expect_out("wr_next", E, 1'b1, PHV_LEN'(16'h00d0));
      @(negedge clk);
      write_entry(4'd3, K2, '0, 1'b0);
      lookup("del3", K2, PHV_LEN'(6), DEF, 1'b0);

`ifdef LKUP_HIT_CNT_EN
      write_entry(4'd4, K3, '0, 1'b1);
      write_action(4'd4, F);
      for (int i = 0; i < 3; i++)
         lookup($sformatf("cnt_hit%0d", i), K3, PHV_LEN'(7 + i), F, 1'b1);
      cnt_rd_addr = 4'd4;
      @(negedge clk);
      chk("cnt.three", PHV_LEN'(cnt_rd_data), PHV_LEN'(3));
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      @(negedge clk);
      chk("cnt.cleared", PHV_LEN'(cnt_rd_data), '0);
`endif

      // Reset with two keys in flight: neither may produce a strobe.
      extract_key = K; phv_in = PHV_LEN'(16'h00e0); key_valid = 1'b1;
      @(negedge clk);
      phv_in = PHV_LEN'(16'h00f0);
      @(negedge clk);
      key_valid = 1'b0; rst_n = 1'b0;
      #1;
      chk("rst_mid.valid_async", PHV_LEN'(action_valid), '0);
      @(negedge clk);
      chk("rst_mid.valid_held", PHV_LEN'(action_valid), '0);
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk($sformatf("rst_mid.after%0d", c), PHV_LEN'(action_valid), '0);
      end
      lookup("post_rst", K, PHV_LEN'(16'h0100), DEF, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
